// File: rtl/exec_dispatch.sv
// In-order dispatch/completion for NUM_UNITS functional units with up to DEPTH
// instructions in flight; a tag FIFO keeps retirement in issue order.
module exec_dispatch #(
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 2,
  parameter int XLEN      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prev_stalled,
  output logic                          stall_prev,
  input  logic                          flush,
  input  logic [NUM_UNITS-1:0]          in_unit_sel,
  input  logic                          in_is_reg_write,
  input  logic [4:0]                    in_rd,
  input  logic                          in_exception,
  input  logic [3:0]                    in_trap_cause,
  output logic [NUM_UNITS-1:0]          unit_issue,
  input  logic [NUM_UNITS-1:0]          unit_done,
  input  logic [NUM_UNITS*XLEN-1:0]     unit_result,
  input  logic [NUM_UNITS-1:0]          unit_exception,
  input  logic [NUM_UNITS*4-1:0]        unit_trap_cause,
  output logic [NUM_UNITS-1:0]          unit_ack,
  output logic                          stall_next,
  output logic                          out_exception,
  output logic [3:0]                    out_trap_cause,
  output logic                          out_is_reg_write,
  output logic [4:0]                    out_reg_write_sel,
  output logic [XLEN-1:0]               out_result,
  output logic [$clog2(DEPTH+1)-1:0]    inflight_count
);

  localparam int UIW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  // Tag FIFO storage; contents are only meaningful between the pointers.
  logic [UIW-1:0] fifo_unit_reg  [DEPTH];
  logic [4:0]     fifo_rd_reg    [DEPTH];
  logic           fifo_wr_reg    [DEPTH];
  logic           fifo_exc_reg   [DEPTH];
  logic [3:0]     fifo_cause_reg [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic            out_valid_reg, out_valid_next;
  logic            out_exc_reg, out_exc_next;
  logic [3:0]      out_cause_reg, out_cause_next;
  logic            out_wr_reg, out_wr_next;
  logic [4:0]      out_sel_reg, out_sel_next;
  logic [XLEN-1:0] out_result_reg, out_result_next;

  logic           accept;
  logic           retire;
  logic [UIW-1:0] in_unit_idx;

  logic [UIW-1:0] head_unit;
  logic [4:0]     head_rd;
  logic           head_wr;
  logic           head_exc;
  logic [3:0]     head_cause;

  logic [NUM_UNITS-1:0] head_hit;
  logic                 head_done;
  logic                 head_unit_exc;
  logic [3:0]           head_unit_cause;
  logic [XLEN-1:0]      head_unit_result;

  assign stall_prev = (count_reg == CW'(DEPTH));
  assign accept     = !prev_stalled && !stall_prev && !flush;

  assign head_unit  = fifo_unit_reg[rd_ptr_reg];
  assign head_rd    = fifo_rd_reg[rd_ptr_reg];
  assign head_wr    = fifo_wr_reg[rd_ptr_reg];
  assign head_exc   = fifo_exc_reg[rd_ptr_reg];
  assign head_cause = fifo_cause_reg[rd_ptr_reg];

  always_comb begin
    in_unit_idx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (in_unit_sel[i]) in_unit_idx = UIW'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign head_hit[gi]   = (head_unit == UIW'(gi));
      assign unit_issue[gi] = accept && in_unit_sel[gi] && !in_exception;
      // Decode-exception entries never touched a unit, so they are never acked.
      assign unit_ack[gi]   = retire && !head_exc && head_hit[gi];
    end
  endgenerate

  always_comb begin
    head_unit_exc    = 1'b0;
    head_unit_cause  = '0;
    head_unit_result = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (head_hit[i]) begin
        head_unit_exc    = unit_exception[i];
        head_unit_cause  = unit_trap_cause[i*4 +: 4];
        head_unit_result = unit_result[i*XLEN +: XLEN];
      end
    end
  end

  assign head_done = |(unit_done & head_hit);
  assign retire    = (count_reg != '0) && !flush && (head_exc || head_done);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (accept) wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (retire) rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      case ({accept, retire})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_comb begin
    out_valid_next  = retire;
    out_exc_next    = out_exc_reg;
    out_cause_next  = out_cause_reg;
    out_wr_next     = out_wr_reg;
    out_sel_next    = out_sel_reg;
    out_result_next = out_result_reg;
    if (retire) begin
      out_exc_next    = head_exc || head_unit_exc;
      out_cause_next  = head_exc ? head_cause : head_unit_cause;
      out_result_next = head_exc ? '0 : head_unit_result;
      // Writes to x0 and trapping instructions never reach the register file.
      out_wr_next     = head_wr && (head_rd != 5'd0) && !(head_exc || head_unit_exc);
      out_sel_next    = out_wr_next ? head_rd : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_exc_reg    <= 1'b0;
      out_cause_reg  <= '0;
      out_wr_reg     <= 1'b0;
      out_sel_reg    <= '0;
      out_result_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      out_valid_reg  <= out_valid_next;
      out_exc_reg    <= out_exc_next;
      out_cause_reg  <= out_cause_next;
      out_wr_reg     <= out_wr_next;
      out_sel_reg    <= out_sel_next;
      out_result_reg <= out_result_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_unit_reg[wr_ptr_reg]  <= in_unit_idx;
      fifo_rd_reg[wr_ptr_reg]    <= in_rd;
      fifo_wr_reg[wr_ptr_reg]    <= in_is_reg_write;
      fifo_exc_reg[wr_ptr_reg]   <= in_exception;
      fifo_cause_reg[wr_ptr_reg] <= in_trap_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && !in_exception) assert ($onehot(in_unit_sel));
  end

  assign stall_next        = !out_valid_reg;
  assign out_exception     = out_exc_reg;
  assign out_trap_cause    = out_cause_reg;
  assign out_is_reg_write  = out_wr_reg;
  assign out_reg_write_sel = out_sel_reg;
  assign out_result        = out_result_reg;
  assign inflight_count    = count_reg;

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed bench for exec_dispatch: expected retirements go into a queue and a
// negedge monitor pops and compares whenever stall_next is low.
module tb_exec_dispatch;

  localparam int NU = 4;
  localparam int XL = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            prev_stalled;
  logic            stall_prev;
  logic            flush;
  logic [NU-1:0]   in_unit_sel;
  logic            in_is_reg_write;
  logic [4:0]      in_rd;
  logic            in_exception;
  logic [3:0]      in_trap_cause;
  logic [NU-1:0]   unit_issue;
  logic [NU-1:0]   unit_done;
  logic [NU*XL-1:0] unit_result;
  logic [NU-1:0]   unit_exception;
  logic [NU*4-1:0] unit_trap_cause;
  logic [NU-1:0]   unit_ack;
  logic            stall_next;
  logic            out_exception;
  logic [3:0]      out_trap_cause;
  logic            out_is_reg_write;
  logic [4:0]      out_reg_write_sel;
  logic [XL-1:0]   out_result;
  logic [1:0]      inflight_count;

  exec_dispatch #(.NUM_UNITS(NU), .DEPTH(2), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .prev_stalled(prev_stalled), .stall_prev(stall_prev),
    .flush(flush), .in_unit_sel(in_unit_sel), .in_is_reg_write(in_is_reg_write),
    .in_rd(in_rd), .in_exception(in_exception), .in_trap_cause(in_trap_cause),
    .unit_issue(unit_issue), .unit_done(unit_done), .unit_result(unit_result),
    .unit_exception(unit_exception), .unit_trap_cause(unit_trap_cause),
    .unit_ack(unit_ack), .stall_next(stall_next), .out_exception(out_exception),
    .out_trap_cause(out_trap_cause), .out_is_reg_write(out_is_reg_write),
    .out_reg_write_sel(out_reg_write_sel), .out_result(out_result),
    .inflight_count(inflight_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [74:0] exp_q[$];

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // {exception, cause, reg_write, sel, result}
  function automatic logic [74:0] mk(input logic e, input logic [3:0] c, input logic w,
                                     input logic [4:0] s, input logic [63:0] r);
    return {e, c, w, s, r};
  endfunction

  always @(negedge clk) begin
    if (!rst && !stall_next) begin
      logic [74:0] act;
      act = {out_exception, out_trap_cause, out_is_reg_write, out_reg_write_sel, out_result};
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got %0h expected none", act);
      end else begin
        logic [74:0] e;
        e = exp_q.pop_front();
        chk("retire", act, e);
        $display("retire exc=%0d cause=%0d wr=%0d sel=%0d result=%0h",
                 out_exception, out_trap_cause, out_is_reg_write, out_reg_write_sel, out_result);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ps, input logic [3:0] sel, input logic [4:0] rd,
                        input logic wr, input logic exc, input logic [3:0] cause);
    prev_stalled = ps; in_unit_sel = sel; in_rd = rd;
    in_is_reg_write = wr; in_exception = exc; in_trap_cause = cause;
  endtask

  task automatic idle();
    set_in(1'b1, 4'b0000, 5'd0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; idle();
    unit_done = '0; unit_result = '0; unit_exception = '0; unit_trap_cause = '0;
    step(); step();
    @(negedge clk);
    chk("reset_count", 75'(inflight_count), 75'(0));
    chk("reset_stall_prev", 75'(stall_prev), 75'(0));
    chk("reset_stall_next", 75'(stall_next), 75'(1));
    chk("reset_outputs", {out_exception, out_trap_cause, out_is_reg_write, out_reg_write_sel, out_result}, 75'(0));
    chk("reset_issue_ack", 75'({unit_issue, unit_ack}), 75'(0));
    step(); rst = 1'b0;
    step();

    // Single int op on unit 1
    set_in(1'b0, 4'b0010, 5'd5, 1'b1, 1'b0, 4'd0);
    exp_q.push_back(mk(1'b0, 4'd0, 1'b1, 5'd5, 64'h1234));
    @(negedge clk); chk("t1_issue", 75'(unit_issue), 75'(4'b0010));
    step(); idle(); unit_done = 4'b0010; unit_result[1*XL +: XL] = 64'h1234;
    @(negedge clk); chk("t1_ack", 75'(unit_ack), 75'(4'b0010));
    chk("t1_count1", 75'(inflight_count), 75'(1));
    step(); unit_done = '0;
    @(negedge clk); chk("t1_count0", 75'(inflight_count), 75'(0));

    // Out-of-order done: unit 3 then unit 1, unit 1 finishes first
    step(); set_in(1'b0, 4'b1000, 5'd7, 1'b1, 1'b0, 4'd0);
    exp_q.push_back(mk(1'b0, 4'd0, 1'b1, 5'd7, 64'hAAAA));
    @(negedge clk); chk("t2_issue3", 75'(unit_issue), 75'(4'b1000));
    step(); set_in(1'b0, 4'b0010, 5'd8, 1'b1, 1'b0, 4'd0);
    exp_q.push_back(mk(1'b0, 4'd0, 1'b1, 5'd8, 64'h1111));
    @(negedge clk); chk("t2_issue1", 75'(unit_issue), 75'(4'b0010));
    step(); idle(); unit_done = 4'b0010; unit_result[1*XL +: XL] = 64'h1111;
    @(negedge clk); chk("t2_full_count", 75'(inflight_count), 75'(2));
    chk("t2_full_stall", 75'(stall_prev), 75'(1));
    chk("t2_no_ack_a", 75'(unit_ack), 75'(0));
    step(); set_in(1'b0, 4'b0001, 5'd11, 1'b1, 1'b0, 4'd0);
    @(negedge clk); chk("t2_held_no_issue", 75'(unit_issue), 75'(0));
    chk("t2_no_ack_b", 75'(unit_ack), 75'(0));
    step(); idle();
    @(negedge clk); chk("t2_no_ack_c", 75'(unit_ack), 75'(0));
    step(); unit_done = 4'b1010; unit_result[3*XL +: XL] = 64'hAAAA;
    @(negedge clk); chk("t2_ack3", 75'(unit_ack), 75'(4'b1000));
    step(); unit_done = 4'b0010;
    @(negedge clk); chk("t2_ack1", 75'(unit_ack), 75'(4'b0010));
    chk("t2_count_after", 75'(inflight_count), 75'(1));
    chk("t2_stall_drop", 75'(stall_prev), 75'(0));
    step(); unit_done = '0;
    @(negedge clk); chk("t2_count0", 75'(inflight_count), 75'(0));

    // Decode exception
    step(); set_in(1'b0, 4'b0100, 5'd9, 1'b1, 1'b1, 4'd2);
    exp_q.push_back(mk(1'b1, 4'd2, 1'b0, 5'd0, 64'h0));
    @(negedge clk); chk("t3_no_issue", 75'(unit_issue), 75'(0));
    step(); idle();
    @(negedge clk); chk("t3_no_ack", 75'(unit_ack), 75'(0));
    chk("t3_count1", 75'(inflight_count), 75'(1));
    step();

    // Flush with two in flight and done raised
    step(); set_in(1'b0, 4'b0001, 5'd3, 1'b1, 1'b0, 4'd0);
    step(); set_in(1'b0, 4'b0100, 5'd4, 1'b1, 1'b0, 4'd0);
    step(); idle(); flush = 1'b1; unit_done = 4'b0101;
    @(negedge clk); chk("t4_count2", 75'(inflight_count), 75'(2));
    chk("t4_no_ack", 75'(unit_ack), 75'(0));
    step(); flush = 1'b0; unit_done = '0;
    @(negedge clk); chk("t4_count0", 75'(inflight_count), 75'(0));
    chk("t4_stall_prev", 75'(stall_prev), 75'(0));
    step(); set_in(1'b0, 4'b0100, 5'd6, 1'b1, 1'b0, 4'd0);
    exp_q.push_back(mk(1'b0, 4'd0, 1'b1, 5'd6, 64'h55));
    @(negedge clk); chk("t4_reissue", 75'(unit_issue), 75'(4'b0100));
    step(); idle(); unit_done = 4'b0100; unit_result[2*XL +: XL] = 64'h55;
    @(negedge clk); chk("t4_ack2", 75'(unit_ack), 75'(4'b0100));
    step(); unit_done = '0;

    // rd=0 write, then accept+retire at count 1, then a unit exception
    step(); set_in(1'b0, 4'b0010, 5'd0, 1'b1, 1'b0, 4'd0);
    exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 5'd0, 64'h77));
    step(); set_in(1'b0, 4'b0001, 5'd10, 1'b1, 1'b0, 4'd0);
    unit_done = 4'b0010; unit_result[1*XL +: XL] = 64'h77;
    exp_q.push_back(mk(1'b1, 4'd5, 1'b0, 5'd0, 64'h99));
    @(negedge clk); chk("t5_ack1", 75'(unit_ack), 75'(4'b0010));
    chk("t5_issue0", 75'(unit_issue), 75'(4'b0001));
    step(); idle(); unit_done = 4'b0001; unit_result[0 +: XL] = 64'h99;
    unit_exception = 4'b0001; unit_trap_cause[3:0] = 4'd5;
    @(negedge clk); chk("t5_count_hold", 75'(inflight_count), 75'(1));
    chk("t5_ack0", 75'(unit_ack), 75'(4'b0001));
    step(); unit_done = '0; unit_exception = '0;
    @(negedge clk); chk("t5_count0", 75'(inflight_count), 75'(0));

    repeat (4) step();
    chk("queue_drained", 75'(exp_q.size()), 75'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
